// File: rtl/audio_chunk_packer.sv
// audio_chunk_packer
// AXI-Stream width up-converter for the audio capture path. Packs N = OUT_W/IN_W
// input words into one OUT_W phrase, least-significant word first. With
// FLUSH_ON_LAST set, tlast closes a phrase early; the unfilled slots are
// PAD_VALUE and tkeep marks the slots that hold real words.
//
// Handshake semantics (both ports): a beat transfers on a rising clk_in edge
// where tvalid and tready are both high. A source never drops tvalid or changes
// its payload until the beat transfers. audio_tready depends only on registered
// state, audio_chunk_tready and audio_tlast, never on audio_tvalid.
// audio_chunk_tdata/tkeep/tlast hold steady while audio_chunk_tvalid is high
// and audio_chunk_tready is low.
module audio_chunk_packer #(
  parameter int               IN_W          = 16,
  parameter int               OUT_W         = 128,
  parameter bit               FLUSH_ON_LAST = 1'b1,
  parameter logic [IN_W-1:0]  PAD_VALUE     = '0,
  localparam int              N             = OUT_W / IN_W,
  localparam int              CW            = $clog2(N) + 1
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              audio_tvalid,
  output logic              audio_tready,
  input  logic [IN_W-1:0]   audio_tdata,
  input  logic              audio_tlast,
  output logic              audio_chunk_tvalid,
  input  logic              audio_chunk_tready,
  output logic [OUT_W-1:0]  audio_chunk_tdata,
  output logic [N-1:0]      audio_chunk_tkeep,
  output logic              audio_chunk_tlast,
  output logic [CW-1:0]     words_pending
);

  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  // Assembly state: words collected so far for the phrase being built.
  logic [CW-1:0]   count;
  logic [IN_W-1:0] asm_q [N];
  logic            last_seen_q;

  // One-deep output register.
  logic             out_valid_q;
  logic [OUT_W-1:0] out_data_q;
  logic [N-1:0]     out_keep_q;
  logic             out_last_q;

  // Handshake and phrase-building terms.
  logic             at_last_slot;
  logic             closes;
  logic             accept_in;
  logic             accept_out;
  logic             completing;
  logic [OUT_W-1:0] phrase_data;
  logic [N-1:0]     phrase_keep;
  logic             phrase_last;

  // A word closes the phrase when it fills the last slot or (flush mode) carries tlast.
  assign at_last_slot = (count == LAST_IDX);
  assign closes       = at_last_slot | (FLUSH_ON_LAST & audio_tlast);

  // Only a closing word needs room in the output register; other words are never stalled.
  assign audio_tready = ~out_valid_q | audio_chunk_tready | ~closes;
  assign accept_in    = audio_tvalid & audio_tready;
  assign completing   = accept_in & closes;
  assign accept_out   = out_valid_q & audio_chunk_tready;

  // Build the phrase as it would look if the current word closed it.
  always_comb begin
    phrase_data = '0;
    phrase_keep = '0;
    phrase_last = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (CW'(i) < count) begin
        phrase_data[i*IN_W +: IN_W] = asm_q[i];
        phrase_keep[i]              = 1'b1;
      end else if (CW'(i) == count) begin
        phrase_data[i*IN_W +: IN_W] = audio_tdata;
        phrase_keep[i]              = 1'b1;
      end else begin
        phrase_data[i*IN_W +: IN_W] = PAD_VALUE;
      end
    end
    // Without early flush a phrase ends a packet if any of its words carried tlast.
    phrase_last = FLUSH_ON_LAST ? audio_tlast : (last_seen_q | audio_tlast);
  end

  // Assembly register: store non-closing words, clear when a phrase is handed off.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      count       <= '0;
      last_seen_q <= 1'b0;
      for (int i = 0; i < N; i++) asm_q[i] <= '0;
    end else if (completing) begin
      count       <= '0;
      last_seen_q <= 1'b0;
      for (int i = 0; i < N; i++) asm_q[i] <= '0;
    end else if (accept_in) begin
      for (int i = 0; i < N; i++) begin
        if (CW'(i) == count) asm_q[i] <= audio_tdata;
      end
      count       <= count + CW'(1);
      last_seen_q <= last_seen_q | audio_tlast;
    end
  end

  // Output register: load on completion (even while draining the previous phrase), else clear on accept.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
    end else if (completing) begin
      out_valid_q <= 1'b1;
      out_data_q  <= phrase_data;
      out_keep_q  <= phrase_keep;
      out_last_q  <= phrase_last;
    end else if (accept_out) begin
      out_valid_q <= 1'b0;
    end
  end

  assign audio_chunk_tvalid = out_valid_q;
  assign audio_chunk_tdata  = out_data_q;
  assign audio_chunk_tkeep  = out_keep_q;
  assign audio_chunk_tlast  = out_last_q;
  assign words_pending      = count;

endmodule

// File: tb/tb_audio_chunk_packer.sv
// Directed bench for audio_chunk_packer: three instances (defaults, flush with
// 0xDEAD padding, no early flush) share one stimulus bus; sel picks which
// instance the running scenario observes.
`timescale 1ns/1ps
module tb_audio_chunk_packer;

  // ---------------- clock / reset / signals ----------------
  logic         clk_in = 1'b0;
  logic         rst_n_in;
  logic         audio_tvalid;
  logic [15:0]  audio_tdata;
  logic         audio_tlast;
  logic         audio_chunk_tready;

  logic a_tready, a_cvalid, a_clast;
  logic p_tready, p_cvalid, p_clast;
  logic f_tready, f_cvalid, f_clast;
  logic [127:0] a_cdata, p_cdata, f_cdata;
  logic [7:0]   a_ckeep, p_ckeep, f_ckeep;
  logic [3:0]   a_pend, p_pend, f_pend;

  logic [1:0]   sel;
  logic         s_tready, s_cvalid, s_clast;
  logic [127:0] s_cdata;
  logic [7:0]   s_ckeep;
  logic [3:0]   s_pend;

  int total = 0;
  int bad   = 0;
  logic [127:0] exp_q[$];

  always #5 clk_in = ~clk_in;

  assign s_tready = (sel == 2'd1) ? p_tready : (sel == 2'd2) ? f_tready : a_tready;
  assign s_cvalid = (sel == 2'd1) ? p_cvalid : (sel == 2'd2) ? f_cvalid : a_cvalid;
  assign s_clast  = (sel == 2'd1) ? p_clast  : (sel == 2'd2) ? f_clast  : a_clast;
  assign s_cdata  = (sel == 2'd1) ? p_cdata  : (sel == 2'd2) ? f_cdata  : a_cdata;
  assign s_ckeep  = (sel == 2'd1) ? p_ckeep  : (sel == 2'd2) ? f_ckeep  : a_ckeep;
  assign s_pend   = (sel == 2'd1) ? p_pend   : (sel == 2'd2) ? f_pend   : a_pend;

  audio_chunk_packer dut_a (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .audio_tvalid(audio_tvalid), .audio_tready(a_tready),
    .audio_tdata(audio_tdata), .audio_tlast(audio_tlast),
    .audio_chunk_tvalid(a_cvalid), .audio_chunk_tready(audio_chunk_tready),
    .audio_chunk_tdata(a_cdata), .audio_chunk_tkeep(a_ckeep),
    .audio_chunk_tlast(a_clast), .words_pending(a_pend)
  );

  audio_chunk_packer #(.FLUSH_ON_LAST(1'b1), .PAD_VALUE(16'hDEAD)) dut_p (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .audio_tvalid(audio_tvalid), .audio_tready(p_tready),
    .audio_tdata(audio_tdata), .audio_tlast(audio_tlast),
    .audio_chunk_tvalid(p_cvalid), .audio_chunk_tready(audio_chunk_tready),
    .audio_chunk_tdata(p_cdata), .audio_chunk_tkeep(p_ckeep),
    .audio_chunk_tlast(p_clast), .words_pending(p_pend)
  );

  audio_chunk_packer #(.FLUSH_ON_LAST(1'b0)) dut_f (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .audio_tvalid(audio_tvalid), .audio_tready(f_tready),
    .audio_tdata(audio_tdata), .audio_tlast(audio_tlast),
    .audio_chunk_tvalid(f_cvalid), .audio_chunk_tready(audio_chunk_tready),
    .audio_chunk_tdata(f_cdata), .audio_chunk_tkeep(f_ckeep),
    .audio_chunk_tlast(f_clast), .words_pending(f_pend)
  );

  // ---------------- driver tasks ----------------
  // One cycle: drive at the falling edge, let combinational paths settle, return.
  task automatic step(input logic v, input logic [15:0] d, input logic l, input logic sr);
    @(negedge clk_in);
    audio_tvalid       = v;
    audio_tdata        = d;
    audio_tlast        = l;
    audio_chunk_tready = sr;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    audio_tvalid = 1'b0; audio_tdata = '0; audio_tlast = 1'b0; audio_chunk_tready = 1'b0;
    rst_n_in = 1'b0;
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    sel = 2'd0;
    @(negedge clk_in);
    audio_tvalid = 1'b0; audio_tdata = '0; audio_tlast = 1'b0; audio_chunk_tready = 1'b0;
    rst_n_in = 1'b0;
    #1;
    total++; if (s_cvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid got=%0b want=0", s_cvalid); end
    total++; if (s_cdata !== 128'h0) begin bad++; $display("FAIL reset_tdata got=%h want=0", s_cdata); end
    total++; if (s_ckeep !== 8'h00) begin bad++; $display("FAIL reset_tkeep got=%h want=00", s_ckeep); end
    total++; if (s_clast !== 1'b0) begin bad++; $display("FAIL reset_tlast got=%0b want=0", s_clast); end
    total++; if (s_pend !== 4'd0) begin bad++; $display("FAIL reset_pending got=%0d want=0", s_pend); end
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;
    #1;
    total++; if (s_tready !== 1'b1) begin bad++; $display("FAIL reset_tready got=%0b want=1", s_tready); end
  endtask

  task automatic test_single_phrase();
    int k = 0;
    int acc8 = -1;
    int first_v = -1;
    int nph = 0;
    logic [127:0] got_d = '0;
    logic [7:0] got_k = '0;
    logic got_l = 1'b1;
    sel = 2'd0;
    do_reset();
    for (int c = 0; c < 30; c++) begin
      step(k < 8, 16'(k + 1), 1'b0, 1'b1);
      if (s_cvalid && first_v < 0) first_v = c;
      if (s_cvalid && audio_chunk_tready) begin
        nph++; got_d = s_cdata; got_k = s_ckeep; got_l = s_clast;
      end
      if (audio_tvalid && s_tready) begin
        k++;
        if (k == 8) acc8 = c;
      end
    end
    total++; if (nph != 1) begin bad++; $display("FAIL single_count got=%0d want=1", nph); end
    total++; if (got_d !== 128'h0008_0007_0006_0005_0004_0003_0002_0001) begin
      bad++; $display("FAIL single_data got=%h want=00080007000600050004000300020001", got_d); end
    total++; if (got_k !== 8'hFF) begin bad++; $display("FAIL single_keep got=%h want=ff", got_k); end
    total++; if (got_l !== 1'b0) begin bad++; $display("FAIL single_last got=%0b want=0", got_l); end
    total++; if (acc8 < 0 || first_v != acc8 + 1) begin
      bad++; $display("FAIL single_latency got=%0d want=%0d", first_v, acc8 + 1); end
    total++; if (s_pend !== 4'd0) begin bad++; $display("FAIL single_pending got=%0d want=0", s_pend); end
  endtask

  task automatic test_continuous();
    int k = 0;
    int nph = 0;
    int drops = 0;
    int acc_q[$];
    int acc_c;
    logic [127:0] build = '0;
    logic [127:0] e;
    sel = 2'd0;
    do_reset();
    exp_q.delete();
    for (int c = 0; c < 80; c++) begin
      step(k < 64, 16'(16'h1000 + k), 1'b0, 1'b1);
      if (s_cvalid && audio_chunk_tready) begin
        nph++;
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL cont_unexpected got=%h want=none", s_cdata);
        end else begin
          e = exp_q.pop_front();
          acc_c = acc_q.pop_front();
          if (s_cdata !== e) begin bad++; $display("FAIL cont_data got=%h want=%h", s_cdata, e); end
          total++;
          if (c != acc_c + 1) begin bad++; $display("FAIL cont_latency got=%0d want=%0d", c, acc_c + 1); end
        end
        total++; if (s_ckeep !== 8'hFF || s_clast !== 1'b0) begin
          bad++; $display("FAIL cont_keep_last got=%h/%0b want=ff/0", s_ckeep, s_clast); end
      end
      if (audio_tvalid) begin
        if (!s_tready) drops++;
        else begin
          build[(k % 8) * 16 +: 16] = audio_tdata;
          k++;
          if (k % 8 == 0) begin exp_q.push_back(build); acc_q.push_back(c); end
        end
      end
    end
    total++; if (drops != 0) begin bad++; $display("FAIL cont_tready_drops got=%0d want=0", drops); end
    total++; if (nph != 8) begin bad++; $display("FAIL cont_phrases got=%0d want=8", nph); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL cont_leftover got=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_flush_pad();
    logic [15:0] wd [12] = '{16'h00A1, 16'h00A2, 16'h00A3, 16'h0055,
                             16'h00B1, 16'h00B2, 16'h00B3, 16'h00B4,
                             16'h00B5, 16'h00B6, 16'h00B7, 16'h00B8};
    logic        wl [12] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                             1'b0, 1'b0, 1'b0, 1'b1};
    logic [127:0] ed [3] = '{128'hDEAD_DEAD_DEAD_DEAD_DEAD_00A3_00A2_00A1,
                             128'hDEAD_DEAD_DEAD_DEAD_DEAD_DEAD_DEAD_0055,
                             128'h00B8_00B7_00B6_00B5_00B4_00B3_00B2_00B1};
    logic [7:0]   ek [3] = '{8'h07, 8'h01, 8'hFF};
    int k = 0;
    int p = 0;
    sel = 2'd1;
    do_reset();
    for (int c = 0; c < 30; c++) begin
      if (k < 12) step(1'b1, wd[k], wl[k], 1'b1);
      else        step(1'b0, 16'h0, 1'b0, 1'b1);
      if (s_cvalid && audio_chunk_tready) begin
        if (p < 3) begin
          total++; if (s_cdata !== ed[p]) begin bad++; $display("FAIL flush_data%0d got=%h want=%h", p, s_cdata, ed[p]); end
          total++; if (s_ckeep !== ek[p]) begin bad++; $display("FAIL flush_keep%0d got=%h want=%h", p, s_ckeep, ek[p]); end
          total++; if (s_clast !== 1'b1) begin bad++; $display("FAIL flush_last%0d got=%0b want=1", p, s_clast); end
        end
        p++;
      end
      if (audio_tvalid && s_tready) k++;
    end
    total++; if (p != 3) begin bad++; $display("FAIL flush_phrases got=%0d want=3", p); end
  endtask

  task automatic test_backpressure();
    logic [127:0] ed [2] = '{128'h4008_4007_4006_4005_4004_4003_4002_4001,
                             128'h4010_400F_400E_400D_400C_400B_400A_4009};
    int k = 0;
    int p = 0;
    int drop_cnt = 0;
    logic sr;
    sel = 2'd0;
    do_reset();
    for (int c = 0; c < 40; c++) begin
      sr = (c >= 20);
      step(k < 16, 16'(16'h4001 + k), 1'b0, sr);
      if (s_cvalid && !sr) begin
        total++; if (s_cdata !== ed[0] || s_ckeep !== 8'hFF) begin
          bad++; $display("FAIL bp_hold got=%h/%h want=%h/ff", s_cdata, s_ckeep, ed[0]); end
      end
      if (s_cvalid && sr) begin
        if (p < 2) begin
          total++; if (s_cdata !== ed[p]) begin bad++; $display("FAIL bp_data%0d got=%h want=%h", p, s_cdata, ed[p]); end
        end
        p++;
      end
      if (audio_tvalid) begin
        if (s_tready) k++;
        else begin
          drop_cnt++;
          total++; if (k != 15) begin bad++; $display("FAIL bp_drop_word got=%0d want=15", k); end
        end
      end
    end
    total++; if (drop_cnt != 5) begin bad++; $display("FAIL bp_drop_cycles got=%0d want=5", drop_cnt); end
    total++; if (k != 16) begin bad++; $display("FAIL bp_accepted got=%0d want=16", k); end
    total++; if (p != 2) begin bad++; $display("FAIL bp_phrases got=%0d want=2", p); end
  endtask

  task automatic test_no_flush();
    logic [127:0] ed [2] = '{128'h3008_3007_3006_3005_3004_3003_3002_3001,
                             128'h3018_3017_3016_3015_3014_3013_3012_3011};
    logic         el [2] = '{1'b1, 1'b0};
    logic [15:0] d;
    int k = 0;
    int p = 0;
    int drops = 0;
    sel = 2'd2;
    do_reset();
    for (int c = 0; c < 30; c++) begin
      d = (k < 8) ? 16'(16'h3001 + k) : 16'(16'h3011 + k - 8);
      step(k < 16, d, (k == 2), 1'b1);
      if (s_cvalid && audio_chunk_tready) begin
        if (p < 2) begin
          total++; if (s_cdata !== ed[p]) begin bad++; $display("FAIL nf_data%0d got=%h want=%h", p, s_cdata, ed[p]); end
          total++; if (s_ckeep !== 8'hFF) begin bad++; $display("FAIL nf_keep%0d got=%h want=ff", p, s_ckeep); end
          total++; if (s_clast !== el[p]) begin bad++; $display("FAIL nf_last%0d got=%0b want=%0b", p, s_clast, el[p]); end
        end
        p++;
      end
      if (audio_tvalid) begin
        if (s_tready) k++; else drops++;
      end
    end
    total++; if (p != 2) begin bad++; $display("FAIL nf_phrases got=%0d want=2", p); end
    total++; if (drops != 0) begin bad++; $display("FAIL nf_drops got=%0d want=0", drops); end
  endtask

  task automatic test_reset_mid();
    int k = 0;
    int p = 0;
    logic [127:0] got_d = '0;
    sel = 2'd0;
    do_reset();
    // Fill one phrase (held, sink not ready) plus five words of the next.
    for (int c = 0; c < 30; c++) begin
      step(1'b1, 16'(16'h5001 + k), 1'b0, 1'b0);
      if (s_tready) k++;
      if (k == 13) break;
    end
    step(1'b0, 16'h0, 1'b0, 1'b0);
    total++; if (s_cvalid !== 1'b1 || s_pend !== 4'd5) begin
      bad++; $display("FAIL rm_before got=%0b/%0d want=1/5", s_cvalid, s_pend); end
    #2 rst_n_in = 1'b0;
    #1;
    total++; if (s_cvalid !== 1'b0) begin bad++; $display("FAIL rm_tvalid got=%0b want=0", s_cvalid); end
    total++; if (s_cdata !== 128'h0) begin bad++; $display("FAIL rm_tdata got=%h want=0", s_cdata); end
    total++; if (s_ckeep !== 8'h00 || s_clast !== 1'b0) begin
      bad++; $display("FAIL rm_keep_last got=%h/%0b want=00/0", s_ckeep, s_clast); end
    total++; if (s_pend !== 4'd0) begin bad++; $display("FAIL rm_pending got=%0d want=0", s_pend); end
    @(negedge clk_in);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    k = 0;
    for (int c = 0; c < 20; c++) begin
      step(k < 8, 16'(16'h6001 + k), 1'b0, 1'b1);
      if (s_cvalid && audio_chunk_tready) begin p++; got_d = s_cdata; end
      if (audio_tvalid && s_tready) k++;
    end
    total++; if (p != 1) begin bad++; $display("FAIL rm_phrases got=%0d want=1", p); end
    total++; if (got_d !== 128'h6008_6007_6006_6005_6004_6003_6002_6001) begin
      bad++; $display("FAIL rm_data got=%h want=60086007600660056004600360026001", got_d); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n_in = 1'b0;
    sel = 2'd0;
    audio_tvalid = 1'b0; audio_tdata = '0; audio_tlast = 1'b0; audio_chunk_tready = 1'b0;
    test_reset();
    test_single_phrase();
    test_continuous();
    test_flush_pad();
    test_backpressure();
    test_no_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
